// File: rtl/cpu_run_ctrl_if.sv
// Core-side commit interface of the run/halt sequencer.
//   cpu_en       : one-cycle commit strobe, driven by the sequencer
//   syscall      : decoded syscall, valid while cpu_en=1
//   v0_value     : $v0 read data (syscall selector)
//   a0_value     : $a0 read data (syscall argument)
//   is_jump      : current instruction is j/jal/jr
//   is_branch    : current instruction is beq/bne
//   branch_taken : branch condition true, meaningful only with is_branch
// master = the core (decode side), slave = cpu_run_ctrl.
interface cpu_run_ctrl_if;
    logic        cpu_en;
    logic        syscall;
    logic [31:0] v0_value;
    logic [31:0] a0_value;
    logic        is_jump;
    logic        is_branch;
    logic        branch_taken;

    modport master (
        input  cpu_en,
        output syscall, v0_value, a0_value, is_jump, is_branch, branch_taken
    );

    modport slave (
        output cpu_en,
        input  syscall, v0_value, a0_value, is_jump, is_branch, branch_taken
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer and statistics unit for the single-cycle MIPS core.
// Issues the cpu_en commit strobe in free-run (paced by tick) or single-step
// (paced by the synchronised rising edge of step_btn) mode, halts on the exit
// syscall, latches the display syscall argument and counts committed
// instructions, jumps, branches and taken branches.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   tick              : free-run rate strobe
//   cont_sw           : 1 = free-run, 0 = single-step
//   step_btn          : debounced asynchronous step button
//   core              : commit interface (cpu_en out, decode info in)
//   halted            : core stopped by the exit syscall
//   syscall_out       : last displayed syscall argument
//   total_cycle       : committed-instruction count (wraps)
//   unconditional     : jump count (saturating)
//   conditional       : conditional-branch count (saturating)
//   conditionalsucces : taken-branch count (saturating)
module cpu_run_ctrl #(
    parameter logic [31:0] HALT_CODE   = 32'd10,
    parameter int unsigned SYNC_STAGES = 2      // legal range 2..4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                cont_sw,
    input  logic                step_btn,
    cpu_run_ctrl_if.slave       core,
    output logic                halted,
    output logic [31:0]         syscall_out,
    output logic [31:0]         total_cycle,
    output logic [15:0]         unconditional,
    output logic [15:0]         conditional,
    output logic [15:0]         conditionalsucces
);

    typedef enum logic [1:0] {StRun, StStep, StHalt} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] step_sync_q;
    logic                   step_prev_q;
    logic                   step_rise_q;
    logic                   cpu_en_q;
    logic                   halt_commit;

    assign core.cpu_en = cpu_en_q;

    // Exit syscall committing in this cycle.
    assign halt_commit = cpu_en_q & core.syscall & (core.v0_value == HALT_CODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= cont_sw ? StRun : StStep;
            step_sync_q       <= '0;
            step_prev_q       <= 1'b0;
            step_rise_q       <= 1'b0;
            cpu_en_q          <= 1'b0;
            halted            <= 1'b0;
            syscall_out       <= 32'd0;
            total_cycle       <= 32'd0;
            unconditional     <= 16'd0;
            conditional       <= 16'd0;
            conditionalsucces <= 16'd0;
        end else begin
            // Synchroniser, then a registered rising-edge detector: a press
            // captured at edge N shows up on cpu_en at edge N+SYNC_STAGES+1.
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_btn};
            step_prev_q <= step_sync_q[SYNC_STAGES-1];
            step_rise_q <= step_sync_q[SYNC_STAGES-1] & ~step_prev_q;

            cpu_en_q <= 1'b0;

            if (cpu_en_q) begin
                total_cycle <= total_cycle + 32'd1;
                if (core.is_jump && unconditional != 16'hFFFF) begin
                    unconditional <= unconditional + 16'd1;
                end
                if (core.is_branch && conditional != 16'hFFFF) begin
                    conditional <= conditional + 16'd1;
                end
                if (core.is_branch && core.branch_taken && conditionalsucces != 16'hFFFF) begin
                    conditionalsucces <= conditionalsucces + 16'd1;
                end
                if (core.syscall && !halt_commit) begin
                    syscall_out <= core.a0_value;
                end
            end

            // Triggers are judged against the current state only; a trigger
            // from the inactive mode is simply dropped.
            case (state_q)
                StRun: begin
                    if (halt_commit) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                    end else begin
                        cpu_en_q <= tick;
                        if (!cont_sw) begin
                            state_q <= StStep;
                        end
                    end
                end
                StStep: begin
                    if (halt_commit) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                    end else begin
                        cpu_en_q <= step_rise_q;
                        if (cont_sw) begin
                            state_q <= StRun;
                        end
                    end
                end
                StHalt: begin
                    // Only rst leaves this state.
                end
                default: begin
                    state_q <= cont_sw ? StRun : StStep;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl. Every expected cpu_en pulse is pushed
// to a queue as its trigger is driven; a negedge monitor pops and compares the
// cycle in which the pulse appears. Counters are checked against bench tallies.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        cont_sw;
    logic        step_btn;
    logic        halted;
    logic [31:0] syscall_out;
    logic [31:0] total_cycle;
    logic [15:0] unconditional;
    logic [15:0] conditional;
    logic [15:0] conditionalsucces;

    cpu_run_ctrl_if core_if ();

    cpu_run_ctrl #(
        .HALT_CODE   (32'd10),
        .SYNC_STAGES (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tick              (tick),
        .cont_sw           (cont_sw),
        .step_btn          (step_btn),
        .core              (core_if),
        .halted            (halted),
        .syscall_out       (syscall_out),
        .total_cycle       (total_cycle),
        .unconditional     (unconditional),
        .conditional       (conditional),
        .conditionalsucces (conditionalsucces)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_q[$];
    int unsigned exp_at;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Scoreboard: each cpu_en pulse must match the next expected cycle.
    always @(negedge clk) begin
        if (core_if.cpu_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("cpu_en_spurious", 32'(core_if.cpu_en), 32'd0);
            end else begin
                exp_at = exp_q.pop_front();
                check_eq("cpu_en_cycle", cyc, exp_at);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One free-run commit: tick now, cpu_en next cycle, decode held through it.
    task automatic commit(input logic j, input logic b, input logic t, input logic sc,
                          input logic [31:0] v0, input logic [31:0] a0, input bit tick_again);
        core_if.is_jump      = j;
        core_if.is_branch    = b;
        core_if.branch_taken = t;
        core_if.syscall      = sc;
        core_if.v0_value     = v0;
        core_if.a0_value     = a0;
        tick                 = 1'b1;
        exp_q.push_back(cyc + 1);
        wait_cycles(1);
        tick = tick_again;  // a tick coincident with the commit itself
        wait_cycles(1);
        tick                 = 1'b0;
        core_if.is_jump      = 1'b0;
        core_if.is_branch    = 1'b0;
        core_if.branch_taken = 1'b0;
        core_if.syscall      = 1'b0;
        core_if.v0_value     = 32'd0;
        core_if.a0_value     = 32'd0;
    endtask

    task automatic check_counts(input logic [31:0] tot, input logic [15:0] unc,
                                input logic [15:0] cnd, input logic [15:0] suc);
        check_eq("total_cycle", total_cycle, tot);
        check_eq("unconditional", 32'(unconditional), 32'(unc));
        check_eq("conditional", 32'(conditional), 32'(cnd));
        check_eq("conditionalsucces", 32'(conditionalsucces), 32'(suc));
    endtask

    task automatic do_reset(input logic mode);
        rst     = 1'b1;
        cont_sw = mode;
        wait_cycles(1);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cont_sw = 1'b1; tick = 1'b0; step_btn = 1'b0;
        core_if.syscall = 1'b0; core_if.v0_value = 32'd0; core_if.a0_value = 32'd0;
        core_if.is_jump = 1'b0; core_if.is_branch = 1'b0; core_if.branch_taken = 1'b0;
        wait_cycles(2);
        check_eq("rst_cpu_en", 32'(core_if.cpu_en), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_syscall_out", syscall_out, 32'd0);
        check_counts(32'd0, 16'd0, 16'd0, 16'd0);
        rst = 1'b0;
        wait_cycles(1);

        // Free-run, one tick every 4th cycle.
        for (int i = 0; i < 20; i++) begin
            commit(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
            wait_cycles(2);
        end
        check_counts(32'd20, 16'd0, 16'd0, 16'd0);
        check_eq("t1_halted", 32'(halted), 32'd0);
        check_eq("t1_pending", exp_q.size(), 32'd0);

        // Single-step: a long hold gives one pulse; ticks are ignored.
        cont_sw = 1'b0;
        wait_cycles(2);
        step_btn = 1'b1;
        exp_q.push_back(cyc + 4);
        for (int i = 0; i < 50; i++) begin
            tick = (i % 3 == 0);
            wait_cycles(1);
        end
        tick = 1'b0; step_btn = 1'b0;
        wait_cycles(10);
        step_btn = 1'b1;
        exp_q.push_back(cyc + 4);
        wait_cycles(10);
        step_btn = 1'b0;
        wait_cycles(6);
        check_eq("t2_pending", exp_q.size(), 32'd0);
        check_eq("t2_total", total_cycle, 32'd22);

        // Jump / branch statistics.
        do_reset(1'b1);
        wait_cycles(1);
        for (int i = 0; i < 5; i++) commit(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) commit(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) commit(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        commit(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        check_counts(32'd13, 16'd5, 16'd7, 16'd3);

        // Display syscall, then halt with a coincident tick that must be dropped.
        commit(1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'h1234_ABCD, 1'b0);
        check_eq("t4_syscall_out", syscall_out, 32'h1234_ABCD);
        check_eq("t4_not_halted", 32'(halted), 32'd0);
        commit(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_eq("t4_still_run", total_cycle, 32'd15);
        commit(1'b0, 1'b0, 1'b0, 1'b1, 32'd10, 32'hDEAD_BEEF, 1'b1);
        check_eq("t4_halted", 32'(halted), 32'd1);
        check_eq("t4_halt_counted", total_cycle, 32'd16);
        for (int i = 0; i < 100; i++) begin
            tick     = 1'b1;
            step_btn = ((i / 5) % 2) == 1;
            cont_sw  = ((i / 10) % 2) == 1;
            wait_cycles(1);
        end
        tick = 1'b0; step_btn = 1'b0; cont_sw = 1'b1;
        wait_cycles(6);
        check_eq("t4_halt_held", 32'(halted), 32'd1);
        check_eq("t4_syscall_held", syscall_out, 32'h1234_ABCD);
        check_counts(32'd16, 16'd5, 16'd7, 16'd3);
        check_eq("t4_pending", exp_q.size(), 32'd0);

        // Back-to-back branch commits saturate the 16-bit counter.
        do_reset(1'b1);
        core_if.is_branch = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick = 1'b1;
            exp_q.push_back(cyc + 1);
            wait_cycles(1);
        end
        tick = 1'b0;
        wait_cycles(1);
        core_if.is_branch = 1'b0;
        check_counts(32'd65540, 16'd0, 16'hFFFF, 16'd0);

        // rst the cycle after a tick (tick still high): in-flight pulse squashed.
        tick = 1'b1;
        exp_q.push_back(cyc + 1);
        wait_cycles(1);
        rst = 1'b1; cont_sw = 1'b0;
        wait_cycles(1);
        tick = 1'b0;
        check_eq("t6_cpu_en", 32'(core_if.cpu_en), 32'd0);
        check_eq("t6_halted", 32'(halted), 32'd0);
        check_counts(32'd0, 16'd0, 16'd0, 16'd0);
        rst = 1'b0;
        wait_cycles(2);
        tick = 1'b1;  // came out of reset in STEP: ignored
        wait_cycles(1);
        tick = 1'b0;
        wait_cycles(3);
        step_btn = 1'b1;
        exp_q.push_back(cyc + 4);
        wait_cycles(4);
        step_btn = 1'b0;
        wait_cycles(4);
        check_eq("t6_step_total", total_cycle, 32'd1);
        check_eq("t6_step_pending", exp_q.size(), 32'd0);

        // rst while halted, with cont_sw=1: back to free-run.
        cont_sw = 1'b1;
        wait_cycles(2);
        commit(1'b0, 1'b0, 1'b0, 1'b1, 32'd10, 32'd0, 1'b0);
        check_eq("t6_halted_set", 32'(halted), 32'd1);
        check_eq("t6_halt_total", total_cycle, 32'd2);
        rst = 1'b1;
        wait_cycles(1);
        check_eq("t6_halt_rst_halted", 32'(halted), 32'd0);
        check_eq("t6_halt_rst_syscall", syscall_out, 32'd0);
        check_counts(32'd0, 16'd0, 16'd0, 16'd0);
        rst = 1'b0;
        commit(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_eq("t6_rerun_total", total_cycle, 32'd1);
        wait_cycles(3);
        check_eq("t6_final_pending", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
